// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample tick every (div_int+1+div_frac/2^FRAC_W) clocks plus mid-bit and bit-end ticks.
// Optional BAUD_GEN_SHADOW_EN: divisor loads are staged and committed at the next bit boundary instead of clearing the counters.
module baud_gen_frac #(
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              sync_clr,
    output logic              tick,
    output logic              mid_tick,
    output logic              bit_tick
);
    localparam int OS_W = $clog2(OVERSAMPLE);

    logic [DIV_W:0]    cnt;
    logic [DIV_W:0]    limit;
    logic [FRAC_W-1:0] facc;
    logic [FRAC_W:0]   facc_sum;
    logic              stretch;
    logic [OS_W-1:0]   os_cnt;
    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic              terminal;
    logic              at_bit_end;
    logic              at_mid;
    logic              clr;

    // One extra bit so an all-ones divisor plus a stretch cycle cannot wrap.
    assign limit      = {1'b0, act_int} + {{DIV_W{1'b0}}, stretch};
    assign facc_sum   = {1'b0, facc} + {1'b0, act_frac};
    assign terminal   = (cnt == limit);
    assign at_bit_end = (os_cnt == OS_W'(OVERSAMPLE - 1));
    assign at_mid     = (os_cnt == OS_W'(OVERSAMPLE / 2 - 1));

`ifdef BAUD_GEN_SHADOW_EN
    logic [DIV_W-1:0]  shd_int;
    logic [FRAC_W-1:0] shd_frac;
    logic              pending;
    logic              commit;

    assign clr    = sync_clr;
    assign commit = en && !sync_clr && terminal && at_bit_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shd_int  <= DIV_W'(DEFAULT_DIV);
            shd_frac <= '0;
            pending  <= 1'b0;
            act_int  <= DIV_W'(DEFAULT_DIV);
            act_frac <= '0;
        end else begin
            if (commit && pending) begin
                act_int  <= shd_int;
                act_frac <= shd_frac;
            end
            // A load landing on the commit edge stays pending for the next bit.
            if (load) begin
                shd_int  <= div_int;
                shd_frac <= div_frac;
                pending  <= 1'b1;
            end else if (commit) begin
                pending  <= 1'b0;
            end
        end
    end
`else
    assign clr = sync_clr | load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_int  <= DIV_W'(DEFAULT_DIV);
            act_frac <= '0;
        end else if (load) begin
            act_int  <= div_int;
            act_frac <= div_frac;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            facc     <= '0;
            stretch  <= 1'b0;
            os_cnt   <= '0;
            tick     <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else if (clr) begin
            cnt      <= '0;
            facc     <= '0;
            stretch  <= 1'b0;
            os_cnt   <= '0;
            tick     <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else if (!en) begin
            tick     <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else if (terminal) begin
            // The fractional carry lengthens only the period that follows.
            cnt      <= '0;
            facc     <= facc_sum[FRAC_W-1:0];
            stretch  <= facc_sum[FRAC_W];
            os_cnt   <= os_cnt + OS_W'(1);
            tick     <= 1'b1;
            mid_tick <= at_mid;
            bit_tick <= at_bit_end;
        end else begin
            cnt      <= cnt + (DIV_W + 1)'(1);
            tick     <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end
    end
endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac (default build, DEFAULT_DIV overridden to 5).
module tb_baud_gen_frac;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        load;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        sync_clr;
    logic        tick;
    logic        mid_tick;
    logic        bit_tick;

    int n_cmp = 0;
    int n_bad = 0;

    baud_gen_frac #(.DIV_W(16), .FRAC_W(4), .OVERSAMPLE(16), .DEFAULT_DIV(5)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .div_int(div_int),
        .div_frac(div_frac), .sync_clr(sync_clr), .tick(tick),
        .mid_tick(mid_tick), .bit_tick(bit_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until tick is seen; -1 if it never comes within the budget.
    task automatic wait_tick(output int n);
        int i;
        n = -1;
        i = 0;
        while (n < 0 && i < 1000) begin
            step();
            i++;
            if (tick === 1'b1) n = i;
        end
    endtask

    task automatic run_ticks(input int cnt, output int total, output int mid_idx,
                             output int bit_idx, output int min_gap, output int max_gap);
        int g;
        total = 0; mid_idx = 0; bit_idx = 0; min_gap = 1000000; max_gap = 0;
        for (int k = 1; k <= cnt; k++) begin
            wait_tick(g);
            if (g < 0) begin
                total = -1;
                break;
            end
            total += g;
            if (g < min_gap) min_gap = g;
            if (g > max_gap) max_gap = g;
            if (mid_tick === 1'b1 && mid_idx == 0) mid_idx = k;
            if (bit_tick === 1'b1 && bit_idx == 0) bit_idx = k;
        end
    endtask

    task automatic do_load(input int di, input int df);
        div_int  = 16'(di);
        div_frac = 4'(df);
        load     = 1'b1;
        step();
        load     = 1'b0;
        chk("load_clears_tick", int'(tick), 0);
    endtask

    int g, tot, mi, bi, mn, mx, viol;

    initial begin
        reset = 1'b1; en = 1'b0; load = 1'b0; sync_clr = 1'b0;
        div_int = '0; div_frac = '0;
        step(); step();
        chk("rst_tick", int'(tick), 0);
        chk("rst_mid", int'(mid_tick), 0);
        chk("rst_bit", int'(bit_tick), 0);

        reset = 1'b0; en = 1'b1;
        wait_tick(g);
        chk("default_first_tick", g, 6);

        // Integer divisor 3: period 4, mid on 8th tick, bit on 16th.
        do_load(3, 0);
        run_ticks(16, tot, mi, bi, mn, mx);
        chk("d3_total", tot, 64);
        chk("d3_min", mn, 4);
        chk("d3_max", mx, 4);
        chk("d3_mid_idx", mi, 8);
        chk("d3_bit_idx", bi, 16);

        // Half-cycle fraction: 4, then alternating 4/5.
        do_load(3, 8);
        run_ticks(1, tot, mi, bi, mn, mx);
        chk("frac_first", tot, 4);
        run_ticks(32, tot, mi, bi, mn, mx);
        chk("frac_total32", tot, 144);
        chk("frac_min", mn, 4);
        chk("frac_max", mx, 5);
        chk("frac_mid_idx", mi, 7);
        chk("frac_bit_idx", bi, 15);

        // Divisor 0: tick every cycle; pause mid-bit and resume in phase.
        do_load(0, 0);
        run_ticks(16, tot, mi, bi, mn, mx);
        chk("d0_total", tot, 16);
        chk("d0_bit_idx", bi, 16);
        run_ticks(5, tot, mi, bi, mn, mx);
        chk("d0_pre_pause", tot, 5);
        en = 1'b0;
        viol = 0;
        repeat (5) begin
            step();
            viol += int'(tick) + int'(mid_tick) + int'(bit_tick);
        end
        chk("pause_quiet", viol, 0);
        en = 1'b1;
        run_ticks(11, tot, mi, bi, mn, mx);
        chk("resume_total", tot, 11);
        chk("resume_mid_idx", mi, 3);
        chk("resume_bit_idx", bi, 11);

        // sync_clr on the terminal-count cycle suppresses the tick and restarts os_cnt.
        do_load(9, 0);
        run_ticks(3, tot, mi, bi, mn, mx);
        chk("d9_pre_total", tot, 30);
        viol = 0;
        repeat (9) begin
            step();
            viol += int'(tick);
        end
        chk("d9_no_early_tick", viol, 0);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        chk("clr_suppress_tick", int'(tick), 0);
        run_ticks(16, tot, mi, bi, mn, mx);
        chk("clr_total", tot, 160);
        chk("clr_min", mn, 10);
        chk("clr_max", mx, 10);
        chk("clr_mid_idx", mi, 8);
        chk("clr_bit_idx", bi, 16);

        // Reset while tick is high.
        do_load(0, 0);
        step();
        chk("pre_reset_tick", int'(tick), 1);
        reset = 1'b1;
        #1;
        chk("async_reset_tick", int'(tick), 0);
        step();
        chk("in_reset_tick", int'(tick), 0);
        reset = 1'b0;
        wait_tick(g);
        chk("post_reset_first_tick", g, 6);

        // Reload mid-bit: counters clear and new spacing applies at once.
        do_load(3, 0);
        run_ticks(5, tot, mi, bi, mn, mx);
        chk("reload_pre_total", tot, 20);
        step(); step();
        do_load(7, 0);
        run_ticks(16, tot, mi, bi, mn, mx);
        chk("reload_total", tot, 128);
        chk("reload_min", mn, 8);
        chk("reload_max", mx, 8);
        chk("reload_bit_idx", bi, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Parametrised fractional baud-rate generator, successor to the fixed small-divisor tick generator used by the UART.
- Produces a 1-cycle oversample tick at an average period of (div_int + 1 + div_frac/2^FRAC_W) clocks.
- Derives a bit-rate tick and a mid-bit sample tick from the oversample count.
- Feeds the UART TX/RX datapaths; sync_clr lets RX realign phase on a start-bit edge.

Parameters:
- DIV_W, 16, width of integer divisor.
- FRAC_W, 4, width of fractional divisor.
- OVERSAMPLE, 16, ticks per bit; power of two, >= 4.
- DEFAULT_DIV, 0, integer divisor loaded at reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- en  in  1  count enable; low freezes all state
- load  in  1  1-cycle strobe: capture div_int/div_frac
- div_int  in  DIV_W  integer divisor (period-1)
- div_frac  in  FRAC_W  fractional divisor, units of 1/2^FRAC_W clock
- sync_clr  in  1  phase realign: clear counters
- tick  out  1  registered oversample pulse
- mid_tick  out  1  registered pulse at mid-bit
- bit_tick  out  1  registered pulse at bit end

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state: all outputs 0; cnt, facc, stretch and os_cnt = 0; act_int = DEFAULT_DIV; act_frac = 0.
- limit = act_int + stretch, computed at DIV_W+1 bits so act_int = all-ones cannot wrap.
- Each edge with en=1 and no clear/load:
  - cnt != limit: cnt++ and tick <= 0.
  - cnt == limit: tick <= 1; cnt <= 0; {carry, facc} <= facc + act_frac; stretch <= carry; os_cnt <= os_cnt + 1 (mod OVERSAMPLE).
- Latency: with div_frac = 0, tick is high in the cycle after the (act_int+1)th enabled edge. Period is act_int+1 cycles; act_int = 0 gives tick every cycle.
- Fractional stretch: a carry adds exactly one cycle to the next period only.
- bit_tick <= 1 together with tick when pre-increment os_cnt == OVERSAMPLE-1.
- mid_tick <= 1 together with tick when pre-increment os_cnt == OVERSAMPLE/2-1.
- en = 0: all counters hold; tick, mid_tick and bit_tick <= 0. Resume continues the same phase.
- sync_clr = 1 (any en): cnt, facc, stretch and os_cnt <= 0; all tick outputs <= 0 that cycle. It takes priority over a coinciding terminal count.
- load = 1 (any en), default build: act_int/act_frac <= inputs, and the counters clear exactly as for sync_clr. load together with sync_clr gives the same single clear.
- Divisor inputs are ignored when load = 0.
- Reset mid-operation: immediate return to reset state, with no pulse emitted.

Optional Feature:
- Macro: BAUD_GEN_SHADOW_EN.
- Defined:
  - load writes shadow registers and sets a pending flag; counters are not cleared.
  - The shadow commits to act_int/act_frac on the same edge that emits bit_tick, and pending clears.
  - A new load while pending overwrites the shadow.
  - sync_clr does not commit or drop a pending update.
  - Reset clears pending; the shadow resets to DEFAULT_DIV/0.
- Undefined: immediate-load behaviour as above; no shadow registers exist.

Test Plan:
- Reset, en=1, load div_int=3, div_frac=0 -> tick every 4 cycles; bit_tick on every 16th tick (64 cycles); mid_tick on 8th tick.
- div_int=3, div_frac=8 (FRAC_W=4) -> tick spacing 4,4,5,4,5,4,5...; 32 ticks after the first span 9*16 cycles ±4.
- div_int=0, div_frac=0 -> tick high every cycle; bit_tick every 16 cycles. Then en=0 for 5 cycles -> no pulses and phase preserved on resume.
- div_int=9, assert sync_clr on the cycle cnt==9 -> no tick that cycle; next tick 10 cycles later; os_cnt restarts, so bit_tick after 16 further ticks.
- Assert reset mid-period with tick pending -> outputs 0 immediately; after release, act_int = DEFAULT_DIV and first tick at DEFAULT_DIV+1 cycles.
- BAUD_GEN_SHADOW_EN build: load div_int=7 mid-bit at div_int=3 -> spacing stays 4 until bit_tick, then becomes 8. Default build, same stimulus -> counters clear on load and spacing becomes 8 at once.
